// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding,
// requester-ID width and the default multiplier latency.
package mult_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_t;

  localparam int ID_W = 1;

  function automatic int default_latency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, combinational from the valids; zero latency.
// Grants only while enabled; last_grant updates on the accepting edge.
module rr_arbiter2
  import mult_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            valid0,
  input  logic            valid1,
  output logic            grant0,
  output logic            grant1,
  output logic [ID_W-1:0] grant_id
);

  logic last_grant;

  // On contention the requester that did not win last time is granted.
  assign grant0   = en & valid0 & (~valid1 | last_grant);
  assign grant1   = en & valid1 & (~valid0 | ~last_grant);
  assign grant_id = ID_W'(grant1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (grant0 | grant1) begin
      last_grant <= grant1;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one fixed-latency multiplier between two requesters; accept to rsp is LATENCY+2 cycles.
// Requesters hold valid until ready; responses are single pulses with no backpressure.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LATENCY = default_latency(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  output logic               rsp0_valid,
  output logic [2*WIDTH-1:0] rsp0_product,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               rsp1_valid,
  output logic [2*WIDTH-1:0] rsp1_product,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_done,
  output logic               busy,
  output logic               timing_fault
);

  localparam int             CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [ID_W-1:0]    id;
  logic [2*WIDTH-1:0] prod;
  logic               grant0;
  logic               grant1;
  logic [ID_W-1:0]    grant_id;
  logic               accept;

  // Gating with rst keeps ready low while reset is asserted.
  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       ((state == IDLE) & rst),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .grant0   (grant0),
    .grant1   (grant1),
    .grant_id (grant_id)
  );

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign accept       = grant0 | grant1;
  assign mul_a        = op_a;
  assign mul_b        = op_b;
  assign rsp0_product = prod;
  assign rsp1_product = prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      id           <= '0;
      prod         <= '0;
      mul_start    <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      busy         <= 1'b0;
      timing_fault <= 1'b0;
    end else begin
      if (mul_done && state != WAIT) timing_fault <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            op_a      <= grant1 ? req1_a : req0_a;
            op_b      <= grant1 ? req1_b : req0_b;
            id        <= grant_id;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          cnt       <= CNT_W'(1);
          state     <= WAIT;
        end
        WAIT: begin
          // Exit time is fixed by the counter alone; done only feeds the fault flag.
          if (cnt == CNT_LAST) begin
            prod       <= mul_product;
            rsp0_valid <= (id == ID_W'(0));
            rsp1_valid <= (id == ID_W'(1));
            if (!mul_done) timing_fault <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (mul_done) timing_fault <= 1'b1;
          end
        end
        RESP: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
